// File: rtl/rop_csr_slave_if.sv
// rtl/rop_csr_slave_if.sv - CSR request/response and lookup bundle for the ROP CSR responder
//
// Groups three channels:
//   read_*   : CSR read request, read_data returned in the same cycle
//   write_*  : CSR write request, no handshake, completes in its cycle
//   lkp_*    : valid/ready warp lookup and its registered response
// Modports: master drives requests (CSR unit / ROP pipeline side),
//           slave is the responder (rop_csr_slave).

interface rop_csr_slave_if #(
  parameter int NUM_WARPS   = 4,
  parameter int NUM_THREADS = 4,
  parameter int NUM_CSRS    = 2,
  parameter int UUID_WIDTH  = 1
);
  localparam int NW_BITS = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

  logic                            read_enable;
  logic [UUID_WIDTH-1:0]           read_uuid;
  logic [NW_BITS-1:0]              read_wid;
  logic [NUM_THREADS-1:0]          read_tmask;
  logic [11:0]                     read_addr;
  logic [NUM_THREADS*32-1:0]       read_data;

  logic                            write_enable;
  logic [UUID_WIDTH-1:0]           write_uuid;
  logic [NW_BITS-1:0]              write_wid;
  logic [NUM_THREADS-1:0]          write_tmask;
  logic [11:0]                     write_addr;
  logic [NUM_THREADS*32-1:0]       write_data;

  logic                            lkp_valid;
  logic [NW_BITS-1:0]              lkp_wid;
  logic                            lkp_ready;
  logic                            lkp_rsp_valid;
  logic [NUM_THREADS*NUM_CSRS*32-1:0] lkp_rsp_data;
  logic                            lkp_rsp_ready;

  modport master (
    output read_enable, read_uuid, read_wid, read_tmask, read_addr,
    input  read_data,
    output write_enable, write_uuid, write_wid, write_tmask, write_addr, write_data,
    output lkp_valid, lkp_wid, lkp_rsp_ready,
    input  lkp_ready, lkp_rsp_valid, lkp_rsp_data
  );

  modport slave (
    input  read_enable, read_uuid, read_wid, read_tmask, read_addr,
    output read_data,
    input  write_enable, write_uuid, write_wid, write_tmask, write_addr, write_data,
    input  lkp_valid, lkp_wid, lkp_rsp_ready,
    output lkp_ready, lkp_rsp_valid, lkp_rsp_data
  );

endinterface

// File: rtl/rop_csr_slave.sv
// rtl/rop_csr_slave.sv - per-warp/per-thread ROP CSR storage with read, write and lookup ports
//
// Ports:
//   clk    : clock
//   reset  : asynchronous active-low reset, clears storage and lookup response
//   csr_if : rop_csr_slave_if.slave
//            read_*  -> combinational read_data (lane i at bits [i*32 +: 32])
//            write_* -> lane-masked update, visible from the next cycle
//            lkp_*   -> one-entry registered lookup, response layout
//                       [lane][csr] at bits [(lane*NUM_CSRS + csr)*32 +: 32]

module rop_csr_slave #(
  parameter int          NUM_WARPS   = 4,
  parameter int          NUM_THREADS = 4,
  parameter int          NUM_CSRS    = 2,
  parameter logic [11:0] CSR_BASE    = 12'h7C0,
  parameter int          UUID_WIDTH  = 1
) (
  input logic             clk,
  input logic             reset,
  rop_csr_slave_if.slave  csr_if
);

  localparam int NW_BITS  = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int RSP_BITS = NUM_THREADS * NUM_CSRS * 32;

  logic [31:0] store [NUM_WARPS][NUM_THREADS][NUM_CSRS];

  // Address decode. The subtraction wraps for addresses below the base, so the
  // lower-bound compare is needed in addition to the index range check.
  logic [11:0] rd_idx;
  logic [11:0] wr_idx;
  logic        rd_in_win;
  logic        wr_in_win;
  logic        wr_hit;

  assign rd_idx    = csr_if.read_addr - CSR_BASE;
  assign wr_idx    = csr_if.write_addr - CSR_BASE;
  assign rd_in_win = (csr_if.read_addr >= CSR_BASE) && (rd_idx < 12'(NUM_CSRS));
  assign wr_in_win = (csr_if.write_addr >= CSR_BASE) && (wr_idx < 12'(NUM_CSRS));
  assign wr_hit    = csr_if.write_enable && wr_in_win;

  // Debug tags travel with requests but carry no function here.
  logic unused_tags;
  assign unused_tags = ^{csr_if.read_uuid, csr_if.write_uuid};

  // Read path: pre-write storage contents, so a same-cycle write is not seen.
  logic [NUM_THREADS*32-1:0] rd_data;

  always_comb begin
    rd_data = '0;
    if (csr_if.read_enable && rd_in_win) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        for (int i = 0; i < NUM_THREADS; i++) begin
          for (int c = 0; c < NUM_CSRS; c++) begin
            if (csr_if.read_wid == NW_BITS'(w) && csr_if.read_tmask[i] &&
                rd_idx == 12'(c)) begin
              rd_data[i*32 +: 32] = store[w][i][c];
            end
          end
        end
      end
    end
  end

  assign csr_if.read_data = rd_data;

  // Lookup capture value: storage of lkp_wid with any same-cycle write to that
  // warp merged in, so the response reflects the write-first view.
  logic [RSP_BITS-1:0] lkp_next;

  always_comb begin
    lkp_next = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      for (int i = 0; i < NUM_THREADS; i++) begin
        for (int c = 0; c < NUM_CSRS; c++) begin
          if (csr_if.lkp_wid == NW_BITS'(w)) begin
            if (wr_hit && csr_if.write_wid == NW_BITS'(w) &&
                csr_if.write_tmask[i] && wr_idx == 12'(c)) begin
              lkp_next[(i*NUM_CSRS + c)*32 +: 32] = csr_if.write_data[i*32 +: 32];
            end else begin
              lkp_next[(i*NUM_CSRS + c)*32 +: 32] = store[w][i][c];
            end
          end
        end
      end
    end
  end

  // Lookup response register. Ready is open whenever the slot is empty or
  // being drained this cycle, which gives one lookup per cycle with no bubble.
  logic                rsp_valid;
  logic [RSP_BITS-1:0] rsp_data;
  logic                lkp_accept;

  assign csr_if.lkp_ready = ~rsp_valid | csr_if.lkp_rsp_ready;
  assign lkp_accept       = csr_if.lkp_valid & csr_if.lkp_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      if (lkp_accept) begin
        rsp_valid <= 1'b1;
        rsp_data  <= lkp_next;
      end else if (csr_if.lkp_rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  assign csr_if.lkp_rsp_valid = rsp_valid;
  assign csr_if.lkp_rsp_data  = rsp_data;

  // CSR storage: only lanes selected by write_tmask in the addressed warp/CSR change.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        for (int i = 0; i < NUM_THREADS; i++) begin
          for (int c = 0; c < NUM_CSRS; c++) begin
            store[w][i][c] <= '0;
          end
        end
      end
    end else if (wr_hit) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        for (int i = 0; i < NUM_THREADS; i++) begin
          for (int c = 0; c < NUM_CSRS; c++) begin
            if (csr_if.write_wid == NW_BITS'(w) && csr_if.write_tmask[i] &&
                wr_idx == 12'(c)) begin
              store[w][i][c] <= csr_if.write_data[i*32 +: 32];
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rop_csr_slave.sv
// tb/tb_rop_csr_slave.sv - directed self-checking bench for rop_csr_slave

module tb_rop_csr_slave;

  localparam int          NUM_WARPS   = 4;
  localparam int          NUM_THREADS = 4;
  localparam int          NUM_CSRS    = 2;
  localparam logic [11:0] CSR_BASE    = 12'h7C0;
  localparam int          UUID_WIDTH  = 1;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  rop_csr_slave_if #(
    .NUM_WARPS(NUM_WARPS), .NUM_THREADS(NUM_THREADS),
    .NUM_CSRS(NUM_CSRS), .UUID_WIDTH(UUID_WIDTH)
  ) bus ();

  rop_csr_slave #(
    .NUM_WARPS(NUM_WARPS), .NUM_THREADS(NUM_THREADS), .NUM_CSRS(NUM_CSRS),
    .CSR_BASE(CSR_BASE), .UUID_WIDTH(UUID_WIDTH)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .csr_if (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Four-lane read_data vector, lane0 in the low word.
  function automatic logic [127:0] lanes(input logic [31:0] l3, input logic [31:0] l2,
                                         input logic [31:0] l1, input logic [31:0] l0);
    return {l3, l2, l1, l0};
  endfunction

  // Lookup response field for [lane][csr].
  function automatic logic [255:0] fld(input int lane, input int csr, input logic [31:0] v);
    logic [255:0] r;
    r = '0;
    r[(lane*NUM_CSRS + csr)*32 +: 32] = v;
    return r;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.read_enable   = 1'b0;
    bus.read_uuid     = '0;
    bus.read_wid      = '0;
    bus.read_tmask    = '0;
    bus.read_addr     = '0;
    bus.write_enable  = 1'b0;
    bus.write_uuid    = '0;
    bus.write_wid     = '0;
    bus.write_tmask   = '0;
    bus.write_addr    = '0;
    bus.write_data    = '0;
    bus.lkp_valid     = 1'b0;
    bus.lkp_wid       = '0;
    bus.lkp_rsp_ready = 1'b0;
  endtask

  task automatic set_read(input logic [1:0] wid, input logic [11:0] addr, input logic [3:0] tmask);
    bus.read_enable = 1'b1;
    bus.read_wid    = wid;
    bus.read_addr   = addr;
    bus.read_tmask  = tmask;
  endtask

  task automatic set_write(input logic [1:0] wid, input logic [11:0] addr,
                           input logic [3:0] tmask, input logic [127:0] data);
    bus.write_enable = 1'b1;
    bus.write_wid    = wid;
    bus.write_addr   = addr;
    bus.write_tmask  = tmask;
    bus.write_data   = data;
  endtask

  logic [255:0] held;
  logic [255:0] exp_w3;

  initial begin
    checks = 0;
    errors = 0;
    idle_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rsp_valid", 256'(bus.lkp_rsp_valid), 256'd0);
    check("reset_lkp_ready", 256'(bus.lkp_ready), 256'd1);
    check("reset_rsp_data", bus.lkp_rsp_data, 256'd0);
    reset = 1'b1;
    next_cycle();

    // Read after reset: all zero.
    set_read(2'd2, CSR_BASE + 12'd1, 4'b1111);
    #1 check("read_after_reset", 256'(bus.read_data), 256'd0);
    bus.read_enable = 1'b0;
    #1 check("read_disabled", 256'(bus.read_data), 256'd0);

    // Masked write to warp 1, CSR 0.
    set_write(2'd1, CSR_BASE, 4'b0101, lanes(32'd4, 32'd3, 32'd2, 32'd1));
    next_cycle();
    bus.write_enable = 1'b0;
    set_read(2'd1, CSR_BASE, 4'b1111);
    #1 check("masked_write_full", 256'(bus.read_data), 256'(lanes(0, 3, 0, 1)));
    bus.read_tmask = 4'b0001;
    #1 check("masked_read_lane0", 256'(bus.read_data), 256'(lanes(0, 0, 0, 1)));

    // Out-of-window write dropped; out-of-window read returns 0.
    bus.read_enable = 1'b0;
    set_write(2'd1, CSR_BASE + 12'd2, 4'b1111, {4{32'hFF}});
    next_cycle();
    bus.write_enable = 1'b0;
    set_read(2'd1, CSR_BASE, 4'b1111);
    #1 check("oow_write_csr0", 256'(bus.read_data), 256'(lanes(0, 3, 0, 1)));
    bus.read_addr = CSR_BASE + 12'd1;
    #1 check("oow_write_csr1", 256'(bus.read_data), 256'd0);
    bus.read_addr = CSR_BASE - 12'd1;
    #1 check("oow_read_below", 256'(bus.read_data), 256'd0);
    bus.read_enable = 1'b0;

    // Same-cycle read and write: read sees old value.
    set_write(2'd0, CSR_BASE, 4'b1111, {4{32'd5}});
    next_cycle();
    set_write(2'd0, CSR_BASE, 4'b1111, {4{32'd9}});
    set_read(2'd0, CSR_BASE, 4'b1111);
    #1 check("rw_same_cycle_old", 256'(bus.read_data), 256'({4{32'd5}}));
    next_cycle();
    bus.write_enable = 1'b0;
    #1 check("rw_next_cycle_new", 256'(bus.read_data), 256'({4{32'd9}}));
    bus.read_enable = 1'b0;

    // Lookup warp 3 with a same-cycle write to warp 3, CSR 1, lane 0.
    set_write(2'd3, CSR_BASE + 12'd1, 4'b0001, lanes(0, 0, 0, 32'h7));
    bus.lkp_valid     = 1'b1;
    bus.lkp_wid       = 2'd3;
    bus.lkp_rsp_ready = 1'b0;
    #1 check("lkp_ready_idle", 256'(bus.lkp_ready), 256'd1);
    next_cycle();
    bus.write_enable = 1'b0;
    check("lkp_fwd_valid", 256'(bus.lkp_rsp_valid), 256'd1);
    check("lkp_fwd_data", bus.lkp_rsp_data, fld(0, 1, 32'h7));
    held = fld(0, 1, 32'h7);

    // Back-pressure: new lookup for warp 1 pending, response held for 3 cycles,
    // with a write to warp 3 during the hold that must not leak into it.
    bus.lkp_wid = 2'd1;
    set_write(2'd3, CSR_BASE, 4'b0010, lanes(0, 0, 32'hAA, 0));
    for (int k = 0; k < 3; k++) begin
      #1 check("bp_lkp_ready", 256'(bus.lkp_ready), 256'd0);
      next_cycle();
      bus.write_enable = 1'b0;
      check("bp_rsp_valid", 256'(bus.lkp_rsp_valid), 256'd1);
      check("bp_data_held", bus.lkp_rsp_data, held);
    end

    // Release: back-to-back responses warp 1, warp 0, warp 3.
    bus.lkp_rsp_ready = 1'b1;
    #1 check("drain_lkp_ready", 256'(bus.lkp_ready), 256'd1);
    next_cycle();
    check("b2b_w1_valid", 256'(bus.lkp_rsp_valid), 256'd1);
    check("b2b_w1_data", bus.lkp_rsp_data, fld(0, 0, 32'd1) | fld(2, 0, 32'd3));
    bus.lkp_wid = 2'd0;
    next_cycle();
    check("b2b_w0_valid", 256'(bus.lkp_rsp_valid), 256'd1);
    check("b2b_w0_data", bus.lkp_rsp_data,
          fld(0, 0, 32'd9) | fld(1, 0, 32'd9) | fld(2, 0, 32'd9) | fld(3, 0, 32'd9));
    bus.lkp_wid = 2'd3;
    next_cycle();
    exp_w3 = fld(0, 1, 32'h7) | fld(1, 0, 32'hAA);
    check("b2b_w3_valid", 256'(bus.lkp_rsp_valid), 256'd1);
    check("b2b_w3_data", bus.lkp_rsp_data, exp_w3);

    // Drain with no new lookup: valid clears.
    bus.lkp_valid = 1'b0;
    next_cycle();
    check("drain_valid_clear", 256'(bus.lkp_rsp_valid), 256'd0);

    // Reset in the middle of a held response.
    bus.lkp_valid     = 1'b1;
    bus.lkp_wid       = 2'd0;
    bus.lkp_rsp_ready = 1'b0;
    next_cycle();
    bus.lkp_valid = 1'b0;
    check("pre_reset_held", 256'(bus.lkp_rsp_valid), 256'd1);
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    check("async_reset_valid", 256'(bus.lkp_rsp_valid), 256'd0);
    check("async_reset_data", bus.lkp_rsp_data, 256'd0);
    set_read(2'd0, CSR_BASE, 4'b1111);
    #1 check("async_reset_storage", 256'(bus.read_data), 256'd0);
    check("async_reset_ready", 256'(bus.lkp_ready), 256'd1);
    bus.read_enable = 1'b0;
    next_cycle();
    reset = 1'b1;
    next_cycle();
    set_read(2'd1, CSR_BASE, 4'b1111);
    #1 check("post_reset_storage_w1", 256'(bus.read_data), 256'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
